// File: rtl/sys_array_nxn.sv
// rtl/sys_array_nxn.sv - N x N output-stationary systolic matrix multiplier
// Operands stream in one k-slice per beat; result rows drain over valid/ready.
module sys_array_nxn #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K_MAX  = 256,
    parameter int KW     = $clog2(K_MAX) + 1,
    parameter int RW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] a_col,
    input  logic [N*DATA_W-1:0] b_row,
    output logic                c_valid,
    input  logic                c_ready,
    output logic [N*ACC_W-1:0]  c_row,
    output logic [RW-1:0]       c_idx,
    output logic                done
);
    localparam int FW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    state_t           state;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_cnt;
    logic [FW-1:0]    f_cnt;
    logic             accept;
    logic             clr;

    logic signed [DATA_W-1:0] a_bus [N][N];
    logic signed [DATA_W-1:0] b_bus [N][N];
    logic                     v_bus [N][N];
    logic [ACC_W-1:0]         acc_w [N][N];

    assign accept = in_valid && in_ready;
    assign clr    = (state == IDLE) && start && (k_len != '0) && (k_len <= KW'(K_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            c_valid  <= 1'b0;
            done     <= 1'b0;
            k_q      <= '0;
            k_cnt    <= '0;
            f_cnt    <= '0;
            c_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (clr) begin
                    k_q      <= k_len;
                    k_cnt    <= '0;
                    busy     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= FEED;
                end
                FEED: if (accept) begin
                    k_cnt <= k_cnt + KW'(1);
                    if (k_cnt == k_q - KW'(1)) begin
                        in_ready <= 1'b0;
                        f_cnt    <= '0;
                        state    <= FLUSH;
                    end
                end
                // 2N-1 cycles lets the last beat reach PE(N-1,N-1)
                FLUSH: if (f_cnt == FW'(2 * N - 2)) begin
                    c_valid <= 1'b1;
                    c_idx   <= '0;
                    state   <= DRAIN;
                end else begin
                    f_cnt <= f_cnt + FW'(1);
                end
                DRAIN: if (c_ready) begin
                    if (c_idx == RW'(N - 1)) begin
                        c_valid <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        c_idx   <= '0;
                        state   <= IDLE;
                    end else begin
                        c_idx <= c_idx + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row i of A and column i of B share the same i+1 stage skew depth
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W-1:0] sa [0:i];
        logic [DATA_W-1:0] sb [0:i];
        logic              sv [0:i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= i; d++) begin
                    sa[d] <= '0;
                    sb[d] <= '0;
                    sv[d] <= 1'b0;
                end
            end else begin
                sa[0] <= a_col[i*DATA_W +: DATA_W];
                sb[0] <= b_row[i*DATA_W +: DATA_W];
                sv[0] <= accept;
                for (int d = 1; d <= i; d++) begin
                    sa[d] <= sa[d-1];
                    sb[d] <= sb[d-1];
                    sv[d] <= sv[d-1];
                end
            end
        end

        assign a_bus[i][0] = sa[i];
        assign v_bus[i][0] = sv[i];
        assign b_bus[0][i] = sb[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [ACC_W-1:0] acc;

            // Operands are sign-extended first so the wrapped product equals sext(a*b)
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc <= '0;
                end else if (clr) begin
                    acc <= '0;
                end else if (v_bus[i][j]) begin
                    acc <= acc + ACC_W'(a_bus[i][j]) * ACC_W'(b_bus[i][j]);
                end
            end
            assign acc_w[i][j] = acc;

            if (j < N - 1) begin : g_fwd_a
                logic signed [DATA_W-1:0] a_q;
                logic                     v_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        a_q <= '0;
                        v_q <= 1'b0;
                    end else begin
                        a_q <= a_bus[i][j];
                        v_q <= v_bus[i][j];
                    end
                end
                assign a_bus[i][j+1] = a_q;
                assign v_bus[i][j+1] = v_q;
            end

            if (i < N - 1) begin : g_fwd_b
                logic signed [DATA_W-1:0] b_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) b_q <= '0;
                    else      b_q <= b_bus[i][j];
                end
                assign b_bus[i+1][j] = b_q;
            end
        end
    end

    always_comb begin
        c_row = '0;
        for (int j = 0; j < N; j++) begin
            c_row[j*ACC_W +: ACC_W] = acc_w[c_idx][j];
        end
    end
endmodule

// File: tb/tb_sys_array_nxn.sv
// tb/tb_sys_array_nxn.sv - self-checking bench for sys_array_nxn
module tb_sys_array_nxn;
    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int K_MAX  = 8;
    localparam int KW     = $clog2(K_MAX) + 1;
    localparam int RW     = $clog2(N);

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [KW-1:0]       k_len;
    logic                busy;
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] a_col;
    logic [N*DATA_W-1:0] b_row;
    logic                c_valid;
    logic                c_ready;
    logic [N*ACC_W-1:0]  c_row;
    logic [RW-1:0]       c_idx;
    logic                done;

    int checks;
    int errors;
    int A [N][K_MAX];
    int B [K_MAX][N];

    sys_array_nxn #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_idx(c_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          k;
        int          fill;
        logic [31:0] gap;
        int          bp_row;
        int          bp_len;
        bit          poke;
        int          exp_cv;
        int          exp_done;
    } job_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain matrix product, wrapped to the accumulator width
    function automatic logic [ACC_W-1:0] ref_c(input int r, input int j, input int k);
        longint      s;
        logic [63:0] t;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(A[r][kk]) * longint'(B[kk][j]);
        t = s;
        return t[ACC_W-1:0];
    endfunction

    task automatic fill_ops(input int mode);
        for (int kk = 0; kk < K_MAX; kk++) begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: begin A[i][kk] = (i == kk) ? 1 : 0; B[kk][i] = kk * N + i + 1; end
                    1: begin A[i][kk] = -3; B[kk][i] = 7; end
                    2: begin A[i][kk] = 2;  B[kk][i] = 5; end
                    default: begin
                        A[i][kk] = int'($urandom_range(0, 65535)) - 32768;
                        B[kk][i] = int'($urandom_range(0, 65535)) - 32768;
                    end
                endcase
            end
        end
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < N; i++) begin
            a_col[i*DATA_W +: DATA_W] = 16'(A[i][b]);
            b_row[i*DATA_W +: DATA_W] = 16'(B[b][i]);
        end
    endtask

    task automatic run_job(input string tag, input int k, input logic [31:0] gap, input int bp_row,
                           input int bp_len, input bit poke, input int exp_cv, input int exp_done);
        int rel, beats, fc, t_last, first_cv, exp_r, stall;
        bit fin;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        k_len = KW'($urandom_range(0, 15));
        rel = 1; beats = 0; fc = 0; t_last = 0; first_cv = -1; exp_r = 0; stall = 0; fin = 1'b0;
        while (!fin && rel < 200) begin
            if (beats < k) begin
                in_valid = !gap[fc % 32];
                fc++;
                drive_beat(beats);
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                a_col = {$urandom(), $urandom()};
                b_row = {$urandom(), $urandom()};
            end
            c_ready = !(exp_r == bp_row && stall < bp_len);
            start = poke && ((rel == 2) || (first_cv >= 0 && exp_r == 1));
            if (start) k_len = KW'(1);
            @(negedge clk);
            chk({tag, " in_ready"}, in_ready, beats < k);
            if (done) begin
                chk({tag, " done cycle"}, rel, (exp_done >= 0) ? exp_done : t_last + 3 * N + bp_len);
                chk({tag, " rows before done"}, exp_r, N);
                chk({tag, " busy at done"}, busy, 0);
                chk({tag, " c_valid at done"}, c_valid, 0);
                fin = 1'b1;
            end else begin
                chk({tag, " busy"}, busy, 1);
                if (c_valid) begin
                    if (first_cv < 0) begin
                        first_cv = rel;
                        chk({tag, " c_valid cycle"}, rel, (exp_cv >= 0) ? exp_cv : t_last + 2 * N);
                    end
                    if (exp_r >= N) begin
                        checks++;
                        errors++;
                        $display("FAIL %s extra row: got c_idx %0d expected no row", tag, c_idx);
                    end else begin
                        chk({tag, " c_idx"}, c_idx, exp_r);
                        for (int j = 0; j < N; j++)
                            chk($sformatf("%s c[%0d][%0d]", tag, exp_r, j), c_row[j*ACC_W +: ACC_W], ref_c(exp_r, j, k));
                    end
                    if (c_ready) exp_r++;
                    else stall++;
                end
            end
            if (in_valid && in_ready) begin
                beats++;
                if (beats == k) t_last = rel;
            end
            @(posedge clk); #1;
            rel++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        c_ready = 1'b1;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done after %0d cycles expected done", tag, rel);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " c_valid"}, c_valid, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " c_row zero"}, c_row == '0, 1);
        chk({tag, " c_idx"}, c_idx, 0);
    endtask

    initial begin
        job_t jobs [6];
        jobs[0] = '{"identity", 2, 0, 32'h0,  0, 0, 1'b0, 10, 14};
        jobs[1] = '{"signed",   3, 1, 32'h0,  0, 0, 1'b0, 11, 15};
        jobs[2] = '{"bubbles",  3, 1, 32'h16, 0, 0, 1'b0, 14, 18};
        jobs[3] = '{"backpres", 3, 3, 32'h0,  1, 5, 1'b0, 11, 20};
        jobs[4] = '{"min_k",    1, 2, 32'h0,  0, 0, 1'b1, 9,  13};
        jobs[5] = '{"max_k",    8, 3, 32'h0,  0, 0, 1'b1, 16, 20};

        checks = 0; errors = 0;
        rst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0; c_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;

        @(posedge clk); #1;
        start = 1'b1; k_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("k_len=0 ignored busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(K_MAX + 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("k_len>K_MAX ignored busy", busy, 0);

        for (int t = 0; t < 6; t++) begin
            fill_ops(jobs[t].fill);
            run_job(jobs[t].tag, jobs[t].k, jobs[t].gap, jobs[t].bp_row, jobs[t].bp_len,
                    jobs[t].poke, jobs[t].exp_cv, jobs[t].exp_done);
        end

        fill_ops(1);
        chk("signed value sext", ref_c(0, 0, 3), 40'hFF_FFFF_FFC1);

        for (int t = 0; t < 6; t++) begin
            fill_ops(3);
            run_job($sformatf("rand%0d", t), int'($urandom_range(1, K_MAX)), $urandom() & $urandom(),
                    int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, -1);
        end

        // Abort a job in FLUSH, then confirm the next job is unaffected
        fill_ops(3);
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            drive_beat(b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-abort busy", busy, 1);
        chk("pre-abort acc nonzero", c_row[ACC_W-1:0] == ref_c(0, 0, 3), 1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("async reset");
        repeat (2) begin
            @(negedge clk);
            chk("held reset done", done, 0);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("after release");
        fill_ops(0);
        run_job("post_reset", 2, 32'h0, 0, 0, 1'b0, 10, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_array_nxn.md
# sys_array_nxn

Parametrised N×N output-stationary systolic matrix multiplier, the successor of the fixed 2×2 array. It computes C = A·B for A (N×K) and B (K×N), where K is set per job at run time. Operands are streamed in one k-slice per beat with on-chip input skewing. Results are drained row by row over a valid/ready handshake, and a single done pulse marks job completion. The block sits between the operand buffers and the result writeback in the matrix_multiplier datapath, using signed fixed-point MACs.

## Interface
- N, 4: array dimension (rows = columns = N), ≥2
- DATA_W, 16: signed operand width
- ACC_W, 40: signed accumulator/result width, ≥2·DATA_W
- K_MAX, 256: maximum inner dimension; KW = $clog2(K_MAX)+1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled in IDLE only
- k_len  in  KW  inner dimension K, captured with start; legal 1..K_MAX
- busy  out  1  high from start accept until done
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- a_col  in  N·DATA_W  A[i][k] in slice i (row 0 in LSBs)
- b_row  in  N·DATA_W  B[k][j] in slice j (column 0 in LSBs)
- c_valid  out  1  result row valid
- c_ready  in  1  result row consumed when c_valid && c_ready
- c_row  out  N·ACC_W  C[r][j] in slice j
- c_idx  out  $clog2(N)  row index r of c_row
- done  out  1  one-cycle pulse after last row is consumed

## Operation
- FSM states: IDLE → FEED → FLUSH → DRAIN → IDLE.
- **IDLE**:
  - start=1 with 1≤k_len≤K_MAX latches k_len, clears all N² accumulators and the beat counter, sets busy, and moves to FEED.
  - start with k_len=0 or k_len>K_MAX is ignored and the FSM stays in IDLE.
- **FEED**:
  - in_ready=1.
  - Each accepted beat is counted and enters the skew registers: row i of A is delayed i cycles and column j of B is delayed j cycles.
  - When the k_len-th beat is accepted, in_ready drops in the next cycle and the FSM moves to FLUSH.
- **Array**:
  - PE(i,j) holds an accumulator and forwards a (with its valid bit) right and b down through one register each.
  - PE(i,j) performs acc += sext(a)·sext(b) only when its incoming valid bit is set.
  - Gaps in in_valid propagate as bubbles and never corrupt the result.
- **FLUSH**: a counter runs for exactly 2N−1 cycles, then the FSM moves to DRAIN.
- **DRAIN**:
  - c_valid=1 with c_idx=r, starting at r=0.
  - On each handshake, r increments.
  - After the handshake with r=N−1: c_valid drops, done pulses, busy clears, and the FSM returns to IDLE.
  - c_row and c_idx stay stable while c_valid && !c_ready.
- **Arithmetic**: two's complement; products are sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W with no saturation.
- start is ignored while busy. k_len changes after capture have no effect.

## Timing
- Reset values (asynchronous, rst low):
  - State is IDLE.
  - busy, in_ready, c_valid and done are 0.
  - c_row, c_idx, all accumulators, skew registers and PE pipeline registers are 0.
- Reset asserted mid-job aborts it immediately. No done pulse is issued, and the first edge after release is in IDLE.
- start is accepted at edge 0. busy=1 and in_ready=1 from cycle 1.
- PE(i,j) uses the beat accepted at cycle t in the cycle t+1+i+j.
- Let t_last be the cycle the final beat is accepted:
  - c_valid first rises at t_last+2N.
  - With c_ready held at 1, row r is presented at t_last+2N+r.
  - done is high at t_last+3N, the same cycle busy and c_valid fall.
- With in_valid and c_ready both held at 1, a job takes k_len+3N cycles from start to done.
- A new start is accepted in the cycle after done.

## Test plan
- **Identity**: N=2, k_len=2, A=I, B=[[1,2],[3,4]], stimulus streamed without gaps → C rows [1,2] and [3,4], c_valid at cycle 6, done at cycle 8.
- **Signed values**: N=4, k_len=3, A all −3, B all 7 → every C element is −63; c_row slices are sign-extended to ACC_W.
- **Input bubbles**: same job as the signed case with in_valid toggled 1,0,0,1,0,1 → identical C; c_valid rises 2N cycles after the third accepted beat.
- **Result backpressure**: c_ready low for 5 cycles during DRAIN at r=1 → c_row and c_idx stay stable, no row is skipped, done follows the row 3 handshake.
- **Minimum K and ignored starts**:
  - k_len=1 job with a=2, b=5 → all elements are 10.
  - start asserted during FEED or DRAIN → ignored, busy stays high.
  - start with k_len=0 → no busy.
- **Reset mid-operation**: rst driven low during FLUSH → all outputs 0 asynchronously, no done pulse; the next job with A=I, B=[[1,2],[3,4]] gives correct results with no residue from the aborted job.
